// File: rtl/branch_predictor.sv
// Direct-mapped bimodal branch predictor with a per-entry tag and target.
// Registered lookup path plus a resolve path that trains the table and flags mispredicts.
module branch_predictor #(
    parameter int unsigned IDX_BITS = 4,
    parameter logic [1:0]  INIT_CTR = 2'b01
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_pc,
    output logic        o_pred_valid,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_res_valid,
    input  logic        i_res_is_branch,
    input  logic [31:0] i_res_pc,
    input  logic        i_res_taken,
    input  logic [31:0] i_res_target,
    input  logic        i_res_pred_taken,
    input  logic [31:0] i_res_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [15:0] o_mispredict_cnt
);
    localparam int unsigned Entries = 1 << IDX_BITS;
    localparam int unsigned TagW    = 30 - IDX_BITS;

    logic [1:0]      ctr_q    [Entries];
    logic [1:0]      ctr_d    [Entries];
    logic            valid_q  [Entries];
    logic            valid_d  [Entries];
    logic [TagW-1:0] tag_q    [Entries];
    logic [TagW-1:0] tag_d    [Entries];
    logic [31:0]     target_q [Entries];
    logic [31:0]     target_d [Entries];

    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic        mispredict_q, mispredict_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX_BITS-1:0] f_idx, r_idx;
    logic [TagW-1:0]     f_tag, r_tag;
    logic                f_taken, upd;
    logic                unused_pc_bits;

    assign f_idx = i_fetch_pc[IDX_BITS+1:2];
    assign f_tag = i_fetch_pc[31:IDX_BITS+2];
    assign r_idx = i_res_pc[IDX_BITS+1:2];
    assign r_tag = i_res_pc[31:IDX_BITS+2];
    assign upd   = i_res_valid && i_res_is_branch;
    assign unused_pc_bits = ^{i_fetch_pc[1:0], i_res_pc[1:0]};

    // Lookup reads the pre-update table, so a same-cycle resolve is seen one cycle later.
    assign f_taken = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];

    always_comb begin
        pred_valid_d  = pred_valid_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (!i_stall) begin
            pred_valid_d = i_fetch_valid;
            if (i_fetch_valid) begin
                pred_taken_d  = f_taken;
                pred_target_d = f_taken ? target_q[f_idx] : i_fetch_pc + 32'd4;
            end
        end
    end

    always_comb begin
        ctr_d    = ctr_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd) begin
            if (i_res_taken) begin
                if (ctr_q[r_idx] != 2'b11) ctr_d[r_idx] = ctr_q[r_idx] + 2'd1;
                valid_d[r_idx]  = 1'b1;
                tag_d[r_idx]    = r_tag;
                target_d[r_idx] = i_res_target;
            end else if (ctr_q[r_idx] != 2'b00) begin
                ctr_d[r_idx] = ctr_q[r_idx] - 2'd1;
            end
        end
    end

    always_comb begin
        mispredict_d = upd && ((i_res_taken != i_res_pred_taken) ||
                               (i_res_taken && i_res_pred_taken &&
                                (i_res_target != i_res_pred_target)));
        redirect_pc_d = redirect_pc_q;
        if (mispredict_d) redirect_pc_d = i_res_taken ? i_res_target : i_res_pc + 32'd4;
        mispredict_cnt_d = mispredict_cnt_q;
        if (mispredict_d && (mispredict_cnt_q != 16'hFFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                ctr_q[i]    <= INIT_CTR;
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_target_q    <= '0;
            mispredict_q     <= 1'b0;
            redirect_pc_q    <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            ctr_q            <= ctr_d;
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            target_q         <= target_d;
            pred_valid_q     <= pred_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
            mispredict_q     <= mispredict_d;
            redirect_pc_q    <= redirect_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign o_pred_valid     = pred_valid_q;
    assign o_pred_taken     = pred_taken_q;
    assign o_pred_target    = pred_target_q;
    assign o_mispredict     = mispredict_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, async-reset sequence,
// then randomized traffic against an array-based reference model.
module tb_branch_predictor;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_fetch_valid;
    logic [31:0] i_fetch_pc;
    logic        o_pred_valid, o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_res_valid, i_res_is_branch, i_res_taken, i_res_pred_taken;
    logic [31:0] i_res_pc, i_res_target, i_res_pred_target;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [15:0] o_mispredict_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall),
        .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc),
        .o_pred_valid(o_pred_valid), .o_pred_taken(o_pred_taken),
        .o_pred_target(o_pred_target), .i_res_valid(i_res_valid),
        .i_res_is_branch(i_res_is_branch), .i_res_pc(i_res_pc),
        .i_res_taken(i_res_taken), .i_res_target(i_res_target),
        .i_res_pred_taken(i_res_pred_taken), .i_res_pred_target(i_res_pred_target),
        .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
        .o_mispredict_cnt(o_mispredict_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        st, fv;
        logic [31:0] fpc;
        logic        rv, rb;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtgt;
        logic        rpt;
        logic [31:0] rptgt;
        logic        epv, ept;
        logic [31:0] eptgt;
        logic        emis;
        logic [31:0] ered;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic fv, input logic [31:0] fpc,
                                input logic rv, input logic rb, input logic [31:0] rpc,
                                input logic rt, input logic [31:0] rtgt, input logic rpt,
                                input logic [31:0] rptgt, input logic epv, input logic ept,
                                input logic [31:0] eptgt, input logic emis,
                                input logic [31:0] ered, input logic [15:0] ecnt);
        vec_t v;
        v.st = st; v.fv = fv; v.fpc = fpc; v.rv = rv; v.rb = rb; v.rpc = rpc;
        v.rt = rt; v.rtgt = rtgt; v.rpt = rpt; v.rptgt = rptgt;
        v.epv = epv; v.ept = ept; v.eptgt = eptgt; v.emis = emis; v.ered = ered;
        v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        i_stall = v.st; i_fetch_valid = v.fv; i_fetch_pc = v.fpc;
        i_res_valid = v.rv; i_res_is_branch = v.rb; i_res_pc = v.rpc;
        i_res_taken = v.rt; i_res_target = v.rtgt;
        i_res_pred_taken = v.rpt; i_res_pred_target = v.rptgt;
    endtask

    task automatic idle();
        i_stall = 0; i_fetch_valid = 0; i_fetch_pc = 0; i_res_valid = 0;
        i_res_is_branch = 0; i_res_pc = 0; i_res_taken = 0; i_res_target = 0;
        i_res_pred_taken = 0; i_res_pred_target = 0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v);
        @(posedge i_clk);
        #1;
        chk({tag, " pred_valid"}, {31'd0, o_pred_valid}, {31'd0, v.epv});
        if (v.epv) begin
            chk({tag, " pred_taken"}, {31'd0, o_pred_taken}, {31'd0, v.ept});
            chk({tag, " pred_target"}, o_pred_target, v.eptgt);
        end
        chk({tag, " mispredict"}, {31'd0, o_mispredict}, {31'd0, v.emis});
        if (v.emis) chk({tag, " redirect_pc"}, o_redirect_pc, v.ered);
        chk({tag, " mis_cnt"}, {16'd0, o_mispredict_cnt}, {16'd0, v.ecnt});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " pred_valid"}, {31'd0, o_pred_valid}, 32'd0);
        chk({tag, " pred_taken"}, {31'd0, o_pred_taken}, 32'd0);
        chk({tag, " pred_target"}, o_pred_target, 32'd0);
        chk({tag, " mispredict"}, {31'd0, o_mispredict}, 32'd0);
        chk({tag, " redirect_pc"}, o_redirect_pc, 32'd0);
        chk({tag, " mis_cnt"}, {16'd0, o_mispredict_cnt}, 32'd0);
    endtask

    // Reference model: 16 entries, index = (pc/4) mod 16, tag = pc/64.
    int          m_ctr [16];
    bit          m_val [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic        e_pv, e_pt, e_mis;
    logic [31:0] e_ptgt, e_red;
    int          e_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ctr[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        e_pv = 0; e_pt = 0; e_ptgt = 0; e_mis = 0; e_red = 0; e_cnt = 0;
    endfunction

    function automatic void model_step();
        int fi, ri;
        fi = int'((i_fetch_pc / 4) % 16);
        ri = int'((i_res_pc / 4) % 16);
        if (!i_stall) begin
            e_pv = i_fetch_valid;
            if (i_fetch_valid) begin
                if (m_val[fi] && m_tag[fi] == i_fetch_pc / 64 && m_ctr[fi] >= 2) begin
                    e_pt = 1; e_ptgt = m_tgt[fi];
                end else begin
                    e_pt = 0; e_ptgt = i_fetch_pc + 4;
                end
            end
        end
        e_mis = 0;
        if (i_res_valid && i_res_is_branch) begin
            e_mis = (i_res_taken != i_res_pred_taken) ||
                    (i_res_taken && i_res_target != i_res_pred_target);
            if (e_mis) begin
                e_red = i_res_taken ? i_res_target : i_res_pc + 4;
                if (e_cnt < 65535) e_cnt++;
            end
            if (i_res_taken) begin
                m_ctr[ri] = (m_ctr[ri] + 1 > 3) ? 3 : m_ctr[ri] + 1;
                m_val[ri] = 1; m_tag[ri] = i_res_pc / 64; m_tgt[ri] = i_res_target;
            end else begin
                m_ctr[ri] = (m_ctr[ri] - 1 < 0) ? 0 : m_ctr[ri] - 1;
            end
        end
    endfunction

    logic [31:0] pc_pool [8];
    logic [31:0] tg_pool [4];

    initial begin
        pc_pool[0] = 32'h100; pc_pool[1] = 32'h140; pc_pool[2] = 32'h104;
        pc_pool[3] = 32'h13C; pc_pool[4] = 32'hFFFF_FFFC; pc_pool[5] = 32'h2000_0100;
        pc_pool[6] = 32'h108; pc_pool[7] = 32'h1C0;
        tg_pool[0] = 32'h200; tg_pool[1] = 32'h400; tg_pool[2] = 32'h800; tg_pool[3] = 32'h0;

        // st fv fpc | rv rb rpc rt rtgt rpt rptgt | epv ept eptgt emis ered ecnt
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,0,32'h104, 0,0,0));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,1,32'h200,0,0,   0,0,0, 1,32'h200,1));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,1,32'h200,0,0,   0,0,0, 1,32'h200,2));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,1,32'h200, 0,0,2));
        vecs.push_back(mk(0,1,32'h140, 0,0,0,0,0,0,0,         1,0,32'h144, 0,0,2));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,0,0,0,0,         0,0,0, 0,0,2));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,0,0,0,0,         0,0,0, 0,0,2));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,0,0,0,0,         0,0,0, 0,0,2));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,0,0,0,0,         0,0,0, 0,0,2));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,0,32'h104, 0,0,2));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,1,32'h200,0,0,   0,0,0, 1,32'h200,3));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,0,32'h104, 0,0,3));
        vecs.push_back(mk(0,1,32'h100, 1,1,32'h100,1,32'h200,0,0, 1,0,32'h104, 1,32'h200,4));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,1,32'h200, 0,0,4));
        vecs.push_back(mk(0,0,0, 1,1,32'hFFFF_FFFC,0,0,1,32'h10, 0,0,0, 1,32'h0,5));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,1,32'h200,1,32'h300, 0,0,0, 1,32'h200,6));
        vecs.push_back(mk(0,0,0, 1,0,32'h100,0,0,1,32'h200,   0,0,0, 0,0,6));
        vecs.push_back(mk(0,0,0, 0,1,32'h100,0,0,1,32'h200,   0,0,0, 0,0,6));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,1,32'h200, 0,0,6));
        vecs.push_back(mk(0,0,0, 1,1,32'h100,1,32'h200,1,32'h200, 0,0,0, 0,0,6));
        // Stall holds the prediction while the resolve path keeps training.
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,1,32'h200, 0,0,6));
        vecs.push_back(mk(1,1,32'h140, 1,1,32'h140,1,32'h400,0,0, 1,1,32'h200, 1,32'h400,7));
        vecs.push_back(mk(1,0,0, 0,0,0,0,0,0,0,               1,1,32'h200, 0,0,7));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0,0,0,               0,0,0, 0,0,7));
        vecs.push_back(mk(0,1,32'h100, 0,0,0,0,0,0,0,         1,0,32'h104, 0,0,7));
        vecs.push_back(mk(0,1,32'h140, 0,0,0,0,0,0,0,         1,1,32'h400, 0,0,7));

        idle();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted mid-flight drops pulse, prediction and trained state.
        apply(mk(0,1,32'h140, 1,1,32'h100,1,32'h200,0,0, 1,1,32'h400, 1,32'h200,8), "midop");
        idle();
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        apply(mk(0,1,32'h140, 0,0,0,0,0,0,0, 1,0,32'h144, 0,0,0), "post_rst");

        // Randomized traffic against the reference model.
        idle();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            i_stall         = ($urandom_range(0, 4) == 0);
            i_fetch_valid   = ($urandom_range(0, 3) != 0);
            i_fetch_pc      = pc_pool[$urandom_range(0, 7)];
            i_res_valid     = ($urandom_range(0, 3) != 0);
            i_res_is_branch = ($urandom_range(0, 5) != 0);
            i_res_pc        = pc_pool[$urandom_range(0, 7)];
            i_res_taken     = $urandom_range(0, 1);
            i_res_target    = ($urandom_range(0, 4) == 0) ? $urandom : tg_pool[$urandom_range(0, 3)];
            i_res_pred_taken  = $urandom_range(0, 1);
            i_res_pred_target = ($urandom_range(0, 1) == 0) ? i_res_target
                                                             : tg_pool[$urandom_range(0, 3)];
            model_step();
            @(posedge i_clk);
            #1;
            chk("rnd pred_valid", {31'd0, o_pred_valid}, {31'd0, e_pv});
            if (e_pv) begin
                chk("rnd pred_taken", {31'd0, o_pred_taken}, {31'd0, e_pt});
                chk("rnd pred_target", o_pred_target, e_ptgt);
            end
            chk("rnd mispredict", {31'd0, o_mispredict}, {31'd0, e_mis});
            if (e_mis) chk("rnd redirect_pc", o_redirect_pc, e_red);
            chk("rnd mis_cnt", {16'd0, o_mispredict_cnt}, e_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
